// File: rtl/ps2_pkg.sv
// Shared encodings and frame constants for the PS/2 mouse receive path.
package ps2_pkg;

   typedef enum logic [1:0] {
      FR_IDLE  = 2'd0,
      FR_DATA  = 2'd1,
      FR_CHECK = 2'd2
   } frame_state_t;

   typedef enum logic [1:0] {
      PK_BYTE1 = 2'd0,
      PK_BYTE2 = 2'd1,
      PK_BYTE3 = 2'd2
   } pkt_state_t;

   localparam int SYNC_BIT   = 3;
   localparam int FRAME_BITS = 10;

   // Frame is {stop, parity, data[7:0]}; odd parity over data+parity, stop high.
   function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
      return (^f[8:0]) & f[9];
   endfunction

endpackage

// File: rtl/ps2_mouse_rx_if.sv
// Pin-side inputs and decoded movement outputs of the PS/2 mouse receiver.
interface ps2_mouse_rx_if;
   logic       ps2c;
   logic       ps2d;
   logic       en;
   logic [8:0] xm;
   logic [8:0] ym;
   logic [2:0] btnm;
   logic [1:0] ovf;
   logic       m_done_tick;
   logic       err_tick;

   modport master (output ps2c, ps2d, en,
                   input  xm, ym, btnm, ovf, m_done_tick, err_tick);
   modport slave  (input  ps2c, ps2d, en,
                   output xm, ym, btnm, ovf, m_done_tick, err_tick);
endinterface

// File: rtl/ps2_rx_frame.sv
// Synchronises and filters ps2c/ps2d and deframes 11-bit PS/2 frames into bytes.
// state    | meaning
// FR_IDLE  | waiting for a start bit (gated by en)
// FR_DATA  | shifting 8 data + parity + stop, LSB first
// FR_CHECK | one cycle: validate parity/stop, emit byte_tick or frame_err
module ps2_rx_frame
   import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       en,
    output logic       byte_tick,
    output logic [7:0] rx_byte,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLOAD = TW'(TIMEOUT - 1);

    logic [1:0]            c_sync, d_sync;
    logic [FILTER_LEN-1:0] filt;
    logic                  fclk, fclk_n, fall_edge, d_s;

    frame_state_t          state, state_n;
    logic [3:0]            cnt, cnt_n;
    logic [FRAME_BITS-1:0] sh, sh_n;
    logic [TW-1:0]         tcnt, tcnt_n;

    assign d_s       = d_sync[1];
    assign fclk_n    = (&filt) ? 1'b1 : ((~|filt) ? 1'b0 : fclk);
    assign fall_edge = fclk & ~fclk_n;
    assign rx_byte   = sh[7:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
            filt   <= '1;
            fclk   <= 1'b1;
            state  <= FR_IDLE;
            cnt    <= '0;
            sh     <= '0;
            tcnt   <= '0;
        end else begin
            c_sync <= {c_sync[0], ps2c};
            d_sync <= {d_sync[0], ps2d};
            filt   <= {filt[FILTER_LEN-2:0], c_sync[1]};
            fclk   <= fclk_n;
            state  <= state_n;
            cnt    <= cnt_n;
            sh     <= sh_n;
            tcnt   <= tcnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sh_n      = sh;
        tcnt_n    = tcnt;
        byte_tick = 1'b0;
        frame_err = 1'b0;
        case (state)
            FR_IDLE: begin
                if (fall_edge && en && !d_s) begin
                    state_n = FR_DATA;
                    cnt_n   = '0;
                    tcnt_n  = TLOAD;
                end
            end
            FR_DATA: begin
                // An edge wins over a coincident timeout.
                if (fall_edge) begin
                    sh_n   = {d_s, sh[FRAME_BITS-1:1]};
                    cnt_n  = cnt + 4'd1;
                    tcnt_n = TLOAD;
                    if (cnt == 4'(FRAME_BITS - 1)) state_n = FR_CHECK;
                end else if (tcnt == '0) begin
                    state_n   = FR_IDLE;
                    frame_err = 1'b1;
                end else begin
                    tcnt_n = tcnt - 1'b1;
                end
            end
            FR_CHECK: begin
                state_n = FR_IDLE;
                if (frame_ok(sh)) byte_tick = 1'b1;
                else              frame_err = 1'b1;
            end
            default: state_n = FR_IDLE;
        endcase
    end

endmodule

// File: rtl/ps2_mouse_rx.sv
// Assembles 3-byte PS/2 stream packets into signed X/Y deltas and button state.
// state    | meaning
// PK_BYTE1 | waiting for a status byte with the sync bit set
// PK_BYTE2 | status latched, waiting for the X byte
// PK_BYTE3 | X latched, waiting for the Y byte; completes the packet
module ps2_mouse_rx
   import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic    clk,
    input  logic    reset,
    ps2_mouse_rx_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLOAD = TW'(TIMEOUT - 1);

    logic       byte_tick, frame_err;
    logic [7:0] rx_byte;

    pkt_state_t    state, state_n;
    logic [7:0]    b1, b1_n, b2, b2_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [8:0]    xm_q, xm_n, ym_q, ym_n;
    logic [2:0]    btn_q, btn_n;
    logic [1:0]    ovf_q, ovf_n;
    logic          done_q, done_n, err_q, err_n;

    ps2_rx_frame #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT   (TIMEOUT)
    ) u_frame (
        .clk      (clk),
        .reset    (reset),
        .ps2c     (bus.ps2c),
        .ps2d     (bus.ps2d),
        .en       (bus.en),
        .byte_tick(byte_tick),
        .rx_byte  (rx_byte),
        .frame_err(frame_err)
    );

    assign bus.xm          = xm_q;
    assign bus.ym          = ym_q;
    assign bus.btnm        = btn_q;
    assign bus.ovf         = ovf_q;
    assign bus.m_done_tick = done_q;
    assign bus.err_tick    = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= PK_BYTE1;
            b1     <= '0;
            b2     <= '0;
            tcnt   <= '0;
            xm_q   <= '0;
            ym_q   <= '0;
            btn_q  <= '0;
            ovf_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            b1     <= b1_n;
            b2     <= b2_n;
            tcnt   <= tcnt_n;
            xm_q   <= xm_n;
            ym_q   <= ym_n;
            btn_q  <= btn_n;
            ovf_q  <= ovf_n;
            done_q <= done_n;
            err_q  <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        b1_n    = b1;
        b2_n    = b2;
        xm_n    = xm_q;
        ym_n    = ym_q;
        btn_n   = btn_q;
        ovf_n   = ovf_q;
        done_n  = 1'b0;
        err_n   = frame_err;
        if (byte_tick)         tcnt_n = TLOAD;
        else if (tcnt != '0)   tcnt_n = tcnt - 1'b1;
        else                   tcnt_n = tcnt;
        case (state)
            PK_BYTE1: begin
                if (byte_tick) begin
                    if (rx_byte[SYNC_BIT]) begin
                        b1_n    = rx_byte;
                        state_n = PK_BYTE2;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            PK_BYTE2: begin
                if (byte_tick) begin
                    b2_n    = rx_byte;
                    state_n = PK_BYTE3;
                end else if (frame_err) begin
                    state_n = PK_BYTE1;
                end else if (tcnt == '0) begin
                    state_n = PK_BYTE1;
                    err_n   = 1'b1;
                end
            end
            PK_BYTE3: begin
                if (byte_tick) begin
                    xm_n    = {b1[4], b2};
                    ym_n    = {b1[5], rx_byte};
                    btn_n   = b1[2:0];
                    ovf_n   = b1[7:6];
                    done_n  = 1'b1;
                    state_n = PK_BYTE1;
                end else if (frame_err) begin
                    state_n = PK_BYTE1;
                end else if (tcnt == '0) begin
                    state_n = PK_BYTE1;
                    err_n   = 1'b1;
                end
            end
            default: state_n = PK_BYTE1;
        endcase
    end

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Directed bench for ps2_mouse_rx: mouse-style stimulus with a packet scoreboard.
module tb_ps2_mouse_rx;
    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 1000;
    localparam int HALF       = 40;

    typedef struct packed {
        logic [8:0] xm;
        logic [8:0] ym;
        logic [2:0] btnm;
        logic [1:0] ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   err_cnt = 0;
    exp_t sb[$];
    exp_t last_exp;

    ps2_mouse_rx_if bus ();

    ps2_mouse_rx #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && bus.err_tick) err_cnt++;
        if (reset && bus.m_done_tick) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_xm",   32'(bus.xm),   32'(e.xm));
                chk("done_ym",   32'(bus.ym),   32'(e.ym));
                chk("done_btnm", 32'(bus.btnm), 32'(e.btnm));
                chk("done_ovf",  32'(bus.ovf),  32'(e.ovf));
            end
        end
    end

    function automatic exp_t model(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        exp_t e;
        e.xm   = {b1[4], b2};
        e.ym   = {b1[5], b3};
        e.btnm = b1[2:0];
        e.ovf  = b1[7:6];
        return e;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        logic        par;
        par = bad_par ? (^b) : ~(^b);
        f   = {1'b1, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.ps2d = f[i];
            wait_clk(HALF / 2);
            bus.ps2c = 1'b0;
            wait_clk(HALF);
            bus.ps2c = 1'b1;
            wait_clk(HALF / 2);
        end
        bus.ps2d = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        send_bits(b, bad_par, 11);
        wait_clk(100);
    endtask

    task automatic send_packet(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        last_exp = model(b1, b2, b3);
        sb.push_back(last_exp);
        send_frame(b1, 0);
        send_frame(b2, 0);
        send_frame(b3, 0);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_outs(input string tag, input exp_t e);
        chk({tag, "_xm"},   32'(bus.xm),   32'(e.xm));
        chk({tag, "_ym"},   32'(bus.ym),   32'(e.ym));
        chk({tag, "_btnm"}, 32'(bus.btnm), 32'(e.btnm));
        chk({tag, "_ovf"},  32'(bus.ovf),  32'(e.ovf));
    endtask

    initial begin
        exp_t zero;
        int   e0;
        zero     = '0;
        reset    = 1'b0;
        bus.ps2c = 1'b1;
        bus.ps2d = 1'b1;
        bus.en   = 1'b1;
        wait_clk(3);
        chk_outs("reset", zero);
        chk("reset_done", 32'(bus.m_done_tick), 32'd0);
        chk("reset_err",  32'(bus.err_tick),    32'd0);
        reset = 1'b1;
        wait_clk(20);

        // Basic packet, negative Y
        e0 = err_cnt;
        send_packet(8'h29, 8'h05, 8'hFB);
        wait_drain("pkt1_drain");
        chk("pkt1_err", 32'(err_cnt - e0), 32'd0);
        chk_outs("pkt1_hold", last_exp);

        // Bad parity frame, then a good packet
        e0 = err_cnt;
        send_frame(8'h08, 1);
        chk("parity_err", 32'(err_cnt - e0), 32'd1);
        chk_outs("parity_hold", last_exp);
        send_packet(8'h08, 8'h10, 8'h20);
        wait_drain("pkt2_drain");
        chk("pkt2_err", 32'(err_cnt - e0), 32'd1);

        // Status byte without sync bit
        e0 = err_cnt;
        send_frame(8'h01, 0);
        chk("sync_err", 32'(err_cnt - e0), 32'd1);
        send_packet(8'h0A, 8'h03, 8'h04);
        wait_drain("pkt3_drain");
        chk("pkt3_err", 32'(err_cnt - e0), 32'd1);

        // Packet timeout after two bytes
        e0 = err_cnt;
        send_frame(8'h08, 0);
        send_frame(8'h10, 0);
        chk("to_before", 32'(err_cnt - e0), 32'd0);
        wait_clk(TIMEOUT + 10);
        chk("to_err", 32'(err_cnt - e0), 32'd1);
        send_packet(8'hC8, 8'h7F, 8'h80);
        wait_drain("pkt4_drain");
        chk("pkt4_err", 32'(err_cnt - e0), 32'd1);

        // Reset in the middle of a packet's third frame
        e0 = err_cnt;
        send_frame(8'h08, 0);
        send_frame(8'h10, 0);
        send_bits(8'h20, 0, 5);
        reset = 1'b0;
        wait_clk(1);
        chk_outs("midrst", zero);
        wait_clk(2);
        chk_outs("midrst_end", zero);
        reset = 1'b1;
        wait_clk(1);
        chk_outs("postrst", zero);
        wait_clk(200);
        e0 = err_cnt;
        send_packet(8'h09, 8'h01, 8'h02);
        wait_drain("pkt5_drain");
        chk("pkt5_err", 32'(err_cnt - e0), 32'd0);

        // Short clock glitch in IDLE, then a frame while disabled
        e0 = err_cnt;
        bus.ps2c = 1'b0;
        wait_clk(3);
        bus.ps2c = 1'b1;
        wait_clk(50);
        bus.en = 1'b0;
        send_frame(8'h08, 0);
        bus.en = 1'b1;
        chk("drop_err", 32'(err_cnt - e0), 32'd0);
        chk_outs("drop_hold", last_exp);
        send_packet(8'h18, 8'h22, 8'h33);
        wait_drain("pkt6_drain");
        chk("pkt6_err", 32'(err_cnt - e0), 32'd0);
        chk_outs("pkt6_final", last_exp);

        wait_clk(20);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ps2_mouse_rx.md
Name: ps2_mouse_rx

Overview:
Receive-side front end for the PS/2 mouse path. It samples ps2c/ps2d, filters the clock, and deframes 11-bit PS/2 frames. It then assembles standard 3-byte stream-mode packets into signed X/Y deltas and button state for the game/movement logic. It sits between the top-level ps2c/ps2d pins and the cursor/ship movement block; this block never drives the PS/2 lines.

Parameters:
FILTER_LEN, 8, ps2c glitch-filter depth in clk cycles (all samples must agree)
TIMEOUT, 100000, clk cycles of inactivity (2 ms at 50 MHz) before a partial frame or packet is abandoned

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low reset
ps2c  in  1  PS/2 clock line (raw, asynchronous)
ps2d  in  1  PS/2 data line (raw, asynchronous)
en  in  1  receive enable; gates only the start of new frames
xm  out  9  X delta, two's complement {sign, byte2}
ym  out  9  Y delta, two's complement {sign, byte3}
btnm  out  3  buttons {middle, right, left} = byte1[2:0]
ovf  out  2  {y_ovf, x_ovf} = byte1[7:6]
m_done_tick  out  1  one-cycle pulse: xm/ym/btnm/ovf updated
err_tick  out  1  one-cycle pulse on any discarded frame/byte/packet

Behaviour:
- Reset (reset=0, asynchronous): xm=0, ym=0, btnm=0, ovf=0, m_done_tick=0, err_tick=0. Frame FSM goes to IDLE, packet FSM to BYTE1, filter register to all ones, filtered clock to 1, timeout counters to 0.
- Sync: ps2c and ps2d each pass through 2 flops before any use.
- Filter: FILTER_LEN-bit shift of synced ps2c. Filtered clock becomes 1 when all bits are 1, becomes 0 when all bits are 0, and holds otherwise. fall_edge is a one-cycle pulse when the filtered clock goes 1->0.
- Frame FSM, states IDLE, DATA, CHECK:
  - IDLE: on fall_edge with en=1 and ps2d=0 (start bit), go to DATA with bit count 0. fall_edge with ps2d=1 is ignored.
  - DATA: each fall_edge shifts ps2d in LSB-first into a 10-bit register (8 data, parity, stop). After the 10th shift, go to CHECK.
  - CHECK (exactly 1 cycle): the frame is valid iff XOR(data, parity)=1 (odd parity) and stop=1. Valid asserts internal byte_tick with the byte; invalid asserts err_tick. Either way, return to IDLE.
  - In DATA, TIMEOUT cycles without fall_edge returns the FSM to IDLE and asserts err_tick.
  - en deasserted mid-frame does not abort the frame.
- Packet FSM, states BYTE1, BYTE2, BYTE3, consuming byte_tick:
  - BYTE1: accept only if byte[3]=1, latching it and going to BYTE2. Otherwise discard, pulse err_tick, and stay in BYTE1.
  - BYTE2: latch X byte, go to BYTE3.
  - BYTE3: on byte_tick, register xm={b1[4],b2}, ym={b1[5],b3}, btnm=b1[2:0], ovf=b1[7:6]. Pulse m_done_tick in the same cycle as the outputs change, then go to BYTE1.
  - Outputs hold until the next completed packet; they do not sign-saturate on ovf.
  - In BYTE2/BYTE3, TIMEOUT cycles without byte_tick returns to BYTE1 with err_tick. The counter clears on every byte_tick.
  - A frame error in BYTE2/BYTE3 also returns to BYTE1. Only one err_tick is asserted per event, even if causes coincide.
- Latency: m_done_tick rises exactly 2 clk cycles after the cycle in which fall_edge of byte 3's stop bit is asserted (CHECK cycle, then packet register).
- Simultaneous events: a frame timeout and a fall_edge in the same cycle resolve as the edge. A packet timeout and a byte_tick in the same cycle resolve as the byte.

Decomposition:
- Shared package ps2_pkg: frame state encoding, packet state encoding, SYNC_BIT=3, FRAME_BITS=10.
- One sub-module, ps2_rx_frame: 2-flop sync, filter, edge detect and frame FSM. It outputs byte_tick, byte[7:0] and frame_err. The packet FSM and output registers live in ps2_mouse_rx.

Test Plan:
- Bench drives ps2c/ps2d as a mouse (bit half-period ≥ 4×FILTER_LEN clk), en=1.
- Packet 0x29,0x05,0xFB -> one m_done_tick; xm=9'h005, ym=9'h1FB (-5), btnm=3'b001, ovf=2'b00; err_tick never asserted.
- Byte 0x08 sent with even parity, then 0x08,0x10,0x20 -> exactly one err_tick and no done for the bad frame; then done with xm=9'h010, ym=9'h020, btnm=3'b000.
- Byte 0x01 (sync bit clear), then 0x0A,0x03,0x04 -> one err_tick; done with xm=9'h003, ym=9'h004, btnm=3'b010.
- 0x08,0x10, idle TIMEOUT+10 cycles, then 0xC8,0x7F,0x80 -> one err_tick at timeout; done with xm=9'h07F, ym=9'h080, ovf=2'b11.
- reset=0 for 3 cycles after 5 bits of a frame, then a full packet 0x09,0x01,0x02 -> outputs 0 during and after reset; the first done has xm=9'h001, ym=9'h002, btnm=3'b001.
- A 3-cycle low glitch on ps2c in IDLE produces no edge, no err_tick and no state change. en=0 during a start bit drops the frame silently, and the next packet decodes normally.
